// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/requester types and width defaults for the memory port arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {REQ_I, REQ_D} req_id_e;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational I/D winner select; ARB_ROUND_ROBIN_EN alternates ties, otherwise D beats I
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req_i,
  input  logic    d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  req_id_e last_grant_i,
`endif
  output logic    any_req_o,
  output req_id_e winner_o
);
  assign any_req_o = i_req_i | d_req_i;
`ifdef ARB_ROUND_ROBIN_EN
  // on a tie the requester that was not granted last goes first
  always_comb winner_o = (i_req_i && d_req_i) ? ((last_grant_i == REQ_D) ? REQ_I : REQ_D) : (d_req_i ? REQ_D : REQ_I);
`else
  // fixed priority: D wins whenever it requests
  always_comb winner_o = d_req_i ? REQ_D : REQ_I;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data_memory port between I-cache and D-cache, one transaction at a time (ARB_ROUND_ROBIN_EN: round-robin ties)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);
  state_e  state_q, state_d;
  logic    seen_busy_q, seen_busy_d;
  logic    d_req, any_req, serving, done;
  req_id_e winner;
`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q, last_grant_d;
`endif
  assign d_req   = d_read | d_write;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign done    = serving && seen_busy_q && !mem_busywait;
  arb_pick u_pick (
    .i_req_i      (i_read),
    .d_req_i      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .any_req_o    (any_req),
    .winner_o     (winner)
  );
  // state, memory-busy-seen flag and (optionally) last grant registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      seen_busy_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_D;
`endif
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end
  // grant from IDLE, hold the SERVE state until memory has gone busy and come back
  always_comb begin
    state_d     = (state_q == IDLE) ? (any_req ? ((winner == REQ_D) ? SERVE_D : SERVE_I) : IDLE) : (done ? IDLE : state_q);
    seen_busy_d = serving && !done && (seen_busy_q || mem_busywait);
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = (state_q == IDLE && any_req) ? winner : last_grant_q;
`endif
  end
  // memory-side mux; strobes drop on done so memory does not start again
  always_comb begin
    mem_read      = !done && ((state_q == SERVE_I) ? i_read : (state_q == SERVE_D) && d_read && !d_write);
    mem_write     = !done && (state_q == SERVE_D) && d_write;
    mem_address   = (state_q == SERVE_I) ? i_address : (state_q == SERVE_D) ? d_address : '0;
    mem_writedata = (state_q == SERVE_D) ? d_writedata : '0;
  end
  assign i_busywait = i_read && !(state_q == SERVE_I && done);
  assign d_busywait = d_req && !(state_q == SERVE_D && done);
  assign i_readdata = mem_readdata;
  assign d_readdata = mem_readdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural data_memory and a shadow memory reference
module tb_mem_port_arbiter;
  typedef struct {
    bit          w;
    logic [5:0]  a;
    logic [31:0] d;
  } exp_t;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_read, d_read, d_write;
  logic [5:0]  i_address, d_address, mem_address;
  logic [31:0] d_writedata, i_readdata, d_readdata, mem_writedata, mem_readdata;
  logic        i_busywait, d_busywait, mem_read, mem_write, mem_busywait;
  int          n_cmp = 0, n_bad = 0;
  int          mem_lat = 5, cnt = 0, naccept = 0;
  logic        op_w;
  logic [5:0]  op_a;
  logic [31:0] op_d;
  logic [31:0] marr [64];
  logic [31:0] ref_mem [64];
  exp_t        i_q [$];
  exp_t        d_q [$];
  exp_t        mi, md;
  bit          tb_last_i = 1'b0;

  mem_port_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(input int k);
    return (k == 5) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(k) * 32'h101;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // data_memory model: accepts a strobe when idle, busy for a latency, then completes
  always @(posedge CLK) begin
    if (RESET) begin
      mem_busywait <= 1'b0;
      cnt          <= 0;
      mem_readdata <= '0;
      for (int k = 0; k < 64; k++) marr[k] <= init_val(k);
    end else if (!mem_busywait) begin
      if (mem_read || mem_write) begin
        mem_busywait <= 1'b1;
        cnt          <= (mem_lat > 0) ? mem_lat - 1 : int'($urandom_range(0, 3));
        op_w         <= mem_write;
        op_a         <= mem_address;
        op_d         <= mem_writedata;
        naccept      <= naccept + 1;
      end
    end else if (cnt == 0) begin
      mem_busywait <= 1'b0;
      if (op_w) marr[op_a] <= op_d;
      else mem_readdata <= marr[op_a];
    end else cnt <= cnt - 1;
  end

  // monitor: every completion a requester sees is checked against its expectation queue
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      if (i_read && !i_busywait) begin
        if (i_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL i_done: unexpected I completion, got 1 required 0");
        end else begin
          mi = i_q.pop_front();
          check("i_rdata", i_readdata, mi.d);
        end
      end
      if ((d_read || d_write) && !d_busywait) begin
        if (d_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_done: unexpected D completion, got 1 required 0");
        end else begin
          md = d_q.pop_front();
          if (md.w) check("d_wmem", marr[md.a], md.d);
          else check("d_rdata", d_readdata, md.d);
        end
      end
    end
  end

  task automatic do_reset();
    RESET = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    i_q.delete(); d_q.delete();
    for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
    tb_last_i = 1'b0;
  endtask

  task automatic wait_own(input bit own_d, input string nm);
    int c;
    c = 0;
    do begin
      @(negedge CLK);
      c++;
    end while ((own_d ? d_busywait : i_busywait) && c < 200);
    if (own_d ? d_busywait : i_busywait) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: busywait 1 after 200 cycles, required 0", nm);
    end
  endtask

  // entered at the negedge before the owner's SERVE cycle; leaves at the following IDLE negedge
  task automatic serve_one(input bit own_d, input bit other_pending, input logic [5:0] addr, input bit wr);
    int c;
    @(negedge CLK);
    check("serve_rd", 32'(mem_read), 32'(!wr));
    check("serve_wr", 32'(mem_write), 32'(wr));
    check("serve_addr", 32'(mem_address), 32'(addr));
    c = 0;
    while ((own_d ? d_busywait : i_busywait) && c < 100) begin
      if (other_pending) check("other_stall", 32'(own_d ? i_busywait : d_busywait), 32'd1);
      @(negedge CLK);
      c++;
    end
    check("serve_done", 32'(own_d ? d_busywait : i_busywait), 32'd0);
    check("done_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    @(posedge CLK);
    #1;
    if (own_d) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
    @(negedge CLK);
    check("idle_gap", {30'd0, mem_read, mem_write}, 32'd0);
  endtask

  task automatic tie_pair(input logic [5:0] da, input logic [31:0] dd, input logic [5:0] ia);
    bit   d_first;
    exp_t e;
    d_first = RR ? tb_last_i : 1'b1;
    e.w = 1'b0; e.a = ia; e.d = ref_mem[ia]; i_q.push_back(e);
    e.w = 1'b1; e.a = da; e.d = dd; d_q.push_back(e);
    ref_mem[da] = dd;
    @(posedge CLK);
    #1 d_write = 1'b1; d_read = 1'b0; d_address = da; d_writedata = dd; i_read = 1'b1; i_address = ia;
    @(negedge CLK);
    check("tie_arb_lat", {30'd0, mem_read, mem_write}, 32'd0);
    serve_one(d_first, 1'b1, d_first ? da : ia, d_first);
    serve_one(!d_first, 1'b0, d_first ? ia : da, !d_first);
    tb_last_i = d_first;
  endtask

  task automatic drive_i(input int n);
    for (int k = 0; k < n; k++) begin
      logic [5:0] a;
      exp_t e;
      a = 6'($urandom_range(0, 31));
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1;
      e.w = 1'b0; e.a = a; e.d = ref_mem[a]; i_q.push_back(e);
      i_read = 1'b1; i_address = a;
      wait_own(1'b0, "i_rand");
      @(posedge CLK);
      #1 i_read = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    for (int k = 0; k < n; k++) begin
      logic [5:0]  a;
      logic [31:0] wd;
      int          op;
      exp_t        e;
      a = 6'(32 + $urandom_range(0, 31));
      op = int'($urandom_range(0, 2));
      wd = $urandom;
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1;
      e.a = a;
      if (op == 0) begin e.w = 1'b0; e.d = ref_mem[a]; end
      else begin e.w = 1'b1; e.d = wd; ref_mem[a] = wd; end
      d_q.push_back(e);
      d_read = (op != 1); d_write = (op != 0); d_address = a; d_writedata = wd;
      wait_own(1'b1, "d_rand");
      @(posedge CLK);
      #1 d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  initial begin
    int   c, snap;
    exp_t e;
    // reset state
    do_reset();
    @(negedge CLK);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", mem_writedata, 32'd0);
    check("rst_i_busy", 32'(i_busywait), 32'd0);
    check("rst_d_busy", 32'(d_busywait), 32'd0);
    // lone I read with five busy cycles
    mem_lat = 5;
    @(posedge CLK);
    #1 i_read = 1'b1; i_address = 6'h05;
    e.w = 1'b0; e.a = 6'h05; e.d = 32'hDEADBEEF; i_q.push_back(e);
    @(negedge CLK);
    check("i_arb_cycle_rd", 32'(mem_read), 32'd0);
    check("i_arb_cycle_busy", 32'(i_busywait), 32'd1);
    @(negedge CLK);
    check("i_rd_rise", 32'(mem_read), 32'd1);
    check("i_rd_addr", 32'(mem_address), 32'h05);
    c = 1;
    while (i_busywait && c < 40) begin
      check("i_only_d_busy", 32'(d_busywait), 32'd0);
      @(negedge CLK);
      c++;
    end
    check("i_done_latency", 32'(c), 32'd7);
    check("i_done_data", i_readdata, 32'hDEADBEEF);
    check("i_done_strobe", 32'(mem_read), 32'd0);
    @(posedge CLK);
    #1 i_read = 1'b0;
    // simultaneous D write and I read, twice
    do_reset();
    mem_lat = 3;
    tie_pair(6'h2A, 32'h12345678, 6'h01);
    tie_pair(6'h30, 32'hCAFEF00D, 6'h02);
    // D with read and write both set behaves as a write
    e.w = 1'b1; e.a = 6'h3F; e.d = 32'h0BADF00D; d_q.push_back(e);
    ref_mem[6'h3F] = 32'h0BADF00D;
    @(posedge CLK);
    #1 d_read = 1'b1; d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'h0BADF00D;
    @(negedge CLK);
    c = 0;
    @(negedge CLK);
    while (d_busywait && c < 60) begin
      check("both_as_write", {30'd0, mem_read, mem_write}, 32'd1);
      check("both_addr", 32'(mem_address), 32'h3F);
      @(negedge CLK);
      c++;
    end
    check("both_done", 32'(d_busywait), 32'd0);
    @(posedge CLK);
    #1 d_read = 1'b0; d_write = 1'b0;
    // reset in the middle of a D read
    mem_lat = 5;
    @(posedge CLK);
    #1 d_read = 1'b1; d_address = 6'h10;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_mid_rd", 32'(mem_read), 32'd1);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_mid_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mid_d_busy", 32'(d_busywait), 32'd1);
    @(posedge CLK);
    #1 RESET = 1'b0; d_read = 1'b0;
    i_q.delete(); d_q.delete();
    for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
    tb_last_i = 1'b0;
    snap = naccept;
    repeat (10) begin
      @(negedge CLK);
      check("post_rst_quiet", {30'd0, mem_read, mem_write}, 32'd0);
    end
    check("post_rst_accepts", 32'(naccept), 32'(snap));
    // random concurrent traffic from both caches
    mem_lat = 0;
    fork
      drive_i(25);
      drive_d(25);
    join
    repeat (3) @(negedge CLK);
    check("i_queue_drained", 32'(i_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_q.size()), 32'd0);
    for (int k = 0; k < 64; k++) check("final_mem", marr[k], ref_mem[k]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required finished");
    $fatal(1, "watchdog");
  end
endmodule
